// File: rtl/pitch_search_ctrl.sv
// Pitch search sequencer: scans the correlation RAM for the peak lag, decides voicing,
// and converts the winning lag to pitch with a restoring divider. Shares the RAM port with a debug reader.
//
// state  | meaning
// IDLE   | waiting for frame_ready; debug reads are granted here
// READ0  | read lag 0, initialise peak tracker
// SCAN   | issue lags LAG_MIN..LAG_MAX, compare data of previous lag
// DRAIN  | compare LAG_MAX data, decide voicing
// DIVIDE | one quotient bit per cycle, FS_DIV / peak lag
// DONE   | pitch/voiced valid, pitch_valid pulse
module pitch_search_ctrl #(
  parameter int LAG_MIN     = 47,
  parameter int LAG_MAX     = 141,
  parameter int FS_DIV      = 12000,
  parameter int VOICE_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_ready,
  output logic [9:0]         corr_addr,
  output logic               corr_rd,
  input  logic signed [71:0] corr_rdata,
  input  logic               dbg_req,
  input  logic [9:0]         dbg_addr,
  output logic               dbg_gnt,
  output logic               dbg_rvalid,
  output logic               busy,
  output logic [13:0]        pitch,
  output logic               voiced,
  output logic               pitch_valid,
  output logic               overrun
);

  typedef enum logic [2:0] {IDLE, READ0, SCAN, DRAIN, DIVIDE, DONE} state_t;

  localparam logic [9:0]         LMIN     = 10'(LAG_MIN);
  localparam logic [9:0]         LMAX     = 10'(LAG_MAX);
  localparam logic [13:0]        DIVIDEND = 14'(FS_DIV);
  localparam logic signed [71:0] MOST_NEG = {1'b1, 71'd0};
  localparam int                 XW       = 72 + VOICE_SHIFT;

  state_t             state;
  logic [9:0]         scan_lag;
  logic signed [71:0] peak;
  logic signed [71:0] r0;
  logic [9:0]         peak_lag;
  logic [13:0]        quo;
  logic [10:0]        rem;
  logic [3:0]         div_cnt;

  logic               take;
  logic [9:0]         data_lag;
  logic signed [71:0] peak_n;
  logic [9:0]         lag_n;
  logic signed [XW-1:0] peak_ext;
  logic signed [XW-1:0] r0_ext;
  logic               voiced_n;
  logic [10:0]        rem_sh;
  logic               sub_ok;
  logic [10:0]        rem_nx;
  logic [13:0]        quo_nx;

  // Data on corr_rdata belongs to the lag issued one cycle earlier.
  assign data_lag = scan_lag - 10'd1;
  assign take     = ((state == SCAN && scan_lag != LMIN) || state == DRAIN) && (corr_rdata > peak);
  assign peak_n   = take ? corr_rdata : peak;
  assign lag_n    = take ? data_lag : peak_lag;

  assign peak_ext = {{VOICE_SHIFT{peak_n[71]}}, peak_n};
  assign r0_ext   = {{VOICE_SHIFT{r0[71]}}, r0};
  assign voiced_n = (peak_n > 0) && ((peak_ext <<< VOICE_SHIFT) >= r0_ext);

  assign rem_sh = {rem[9:0], quo[13]};
  assign sub_ok = rem_sh >= {1'b0, peak_lag};
  assign rem_nx = sub_ok ? (rem_sh - {1'b0, peak_lag}) : rem_sh;
  assign quo_nx = {quo[12:0], sub_ok};

  assign busy = (state != IDLE);

  always_comb begin
    corr_addr = 10'd0;
    corr_rd   = 1'b0;
    dbg_gnt   = 1'b0;
    case (state)
      IDLE: begin
        if (!frame_ready && dbg_req) begin
          corr_addr = dbg_addr;
          corr_rd   = 1'b1;
          dbg_gnt   = 1'b1;
        end
      end
      READ0: corr_rd = 1'b1;
      SCAN: begin
        corr_addr = scan_lag;
        corr_rd   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      scan_lag    <= 10'd0;
      peak        <= MOST_NEG;
      r0          <= 72'sd0;
      peak_lag    <= 10'd0;
      quo         <= 14'd0;
      rem         <= 11'd0;
      div_cnt     <= 4'd0;
      pitch       <= 14'd0;
      voiced      <= 1'b0;
      pitch_valid <= 1'b0;
      overrun     <= 1'b0;
      dbg_rvalid  <= 1'b0;
    end else begin
      dbg_rvalid <= dbg_gnt;
      if (frame_ready && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          pitch_valid <= 1'b0;
          if (frame_ready) state <= READ0;
        end
        READ0: begin
          peak     <= MOST_NEG;
          peak_lag <= LMIN;
          scan_lag <= LMIN;
          state    <= SCAN;
        end
        SCAN: begin
          if (scan_lag == LMIN) r0 <= corr_rdata;
          peak     <= peak_n;
          peak_lag <= lag_n;
          scan_lag <= scan_lag + 10'd1;
          if (scan_lag == LMAX) state <= DRAIN;
        end
        DRAIN: begin
          peak     <= peak_n;
          peak_lag <= lag_n;
          if (voiced_n) begin
            rem     <= 11'd0;
            quo     <= DIVIDEND;
            div_cnt <= 4'd13;
            state   <= DIVIDE;
          end else begin
            pitch       <= 14'd0;
            voiced      <= 1'b0;
            pitch_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DIVIDE: begin
          rem     <= rem_nx;
          quo     <= quo_nx;
          div_cnt <= div_cnt - 4'd1;
          if (div_cnt == 4'd0) begin
            pitch       <= quo_nx;
            voiced      <= 1'b1;
            pitch_valid <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          pitch_valid <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
